dm_sba_arbiter: RTL and testbench
=================================

Name: dm_sba_arbiter

Overview:
Shares the debug module's single system-bus master port between NrMasters requesters, e.g. the SBA engine plus a future trace/abstract-memory-access unit. Arbitration is round-robin. The selected address phase is held stable until the bus grants it. Up to MaxOutstanding granted transactions are tracked in order, so each read response and write acknowledge is routed back to the requester that issued it. Sits between the requesters and the top-level master_* ports.

Parameters:
NrMasters, 2, number of requesters (>=2)
BusWidth, 32, address/data width (32 or 64)
MaxOutstanding, 2, max granted-but-unanswered transactions (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NrMasters  per-requester request, held until its gnt_o
we_i  in  NrMasters  per-requester write enable
addr_i  in  NrMasters x BusWidth  per-requester address
be_i  in  NrMasters x BusWidth/8  per-requester byte enables
wdata_i  in  NrMasters x BusWidth  per-requester write data
gnt_o  out  NrMasters  one-hot grant, combinational from master_gnt_i
r_valid_o  out  NrMasters  one-hot response valid
r_rdata_o  out  BusWidth  response data, broadcast to all requesters
master_req_o  out  1  bus request
master_add_o  out  BusWidth  bus address
master_we_o  out  1  bus write enable
master_wdata_o  out  BusWidth  bus write data
master_be_o  out  BusWidth/8  bus byte enables
master_gnt_i  in  1  bus grant
master_r_valid_i  in  1  bus response valid (in order)
master_r_rdata_i  in  BusWidth  bus response data
resp_err_o  out  1  one-cycle pulse on an unexpected response

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-low (rst_ni).
- Reset state:
  - rr_ptr=0, lock=0, outstanding FIFO empty.
  - All outputs 0: gnt_o, r_valid_o, master_req_o, master_we_o, master_be_o, resp_err_o, master_add_o, master_wdata_o, r_rdata_o.
- Selection:
  - If lock=0: winner = first requester with req_i set, searching from rr_ptr upward modulo NrMasters.
  - If lock=1: winner = locked index.
- master_req_o = (winner valid) AND (FIFO not full).
  - master_add_o, master_we_o, master_be_o, master_wdata_o are muxed from the winner.
  - They are 0 when there is no winner.
- Lock rule (address phase stability):
  - master_req_o=1 and master_gnt_i=0 -> next cycle lock=1 on the same index.
  - Lock clears on a grant.
  - No re-arbitration while locked, even if a higher-priority requester arrives.
- Grant:
  - gnt_o[winner] = master_req_o AND master_gnt_i, same cycle (zero latency).
  - On a grant: push the winner index into the FIFO; rr_ptr <= winner+1 mod NrMasters; lock <= 0.
- Response:
  - On master_r_valid_i with the FIFO non-empty: r_valid_o[head]=1 in the same cycle; r_rdata_o = master_r_rdata_i; pop.
  - Responses are assumed to arrive >=1 cycle after their grant.
- Unexpected response: master_r_valid_i with the FIFO empty -> r_valid_o stays 0, resp_err_o=1 for that cycle, no state change.
- FIFO full (MaxOutstanding entries) -> master_req_o=0, no grant. If a pop happens the same cycle, the request is still blocked; it is re-evaluated next cycle.
- Simultaneous grant and response: push and pop in the same cycle; the occupancy count is unchanged.
- req_i deasserting before its gnt_o is a protocol violation by the requester. It is not checked; the lock is dropped only on a grant.
- Reset asserted mid-transaction: FIFO and lock cleared immediately. Late bus responses after reset produce resp_err_o pulses only.
- FIFO pointer widths: $clog2(MaxOutstanding), minimum 1, with a separate occupancy counter of width $clog2(MaxOutstanding+1).

Decomposition:
- dm package: add localparam SbaMaxOutstanding=2 and typedef sba_req_t (we, addr, be, wdata).
- Sub-module dm_sba_id_fifo: in-order FIFO of $clog2(NrMasters)-bit indices. Ports: push, pop, data in/out, full, empty. Asynchronous reset clears it.
- The arbiter is the parent and instantiates that FIFO.

Test Plan:
1. Reset: hold rst_ni=0 with all req_i=1 -> every output 0. Release with master_gnt_i=1 -> gnt_o=2'b01 on the first cycle.
2. Round-robin: req_i=2'b11 continuously, master_gnt_i=1, responses 1 cycle later -> grants alternate 01,10,01,10; r_valid_o follows the same sequence one cycle behind.
3. Lock: req_i=2'b10, master_gnt_i=0 for 3 cycles, then req_i[0] rises -> master_add_o stays addr_i[1] and gnt_o=2'b10 when the grant arrives.
4. Full: MaxOutstanding=2, two grants and no responses -> master_req_o=0 on the third request. One response (0xDEADBEEF) -> r_valid_o to the first grantee with r_rdata_o=0xDEADBEEF, and master_req_o=1 the next cycle.
5. Simultaneous: FIFO holding 1 entry, grant and response in the same cycle -> occupancy stays 1 and the response goes to the older ID.
6. Unexpected response: master_r_valid_i=1 with the FIFO empty -> resp_err_o=1 for 1 cycle, r_valid_o=0. Reset mid-flight, then a response -> same result.

Source files
------------

// File: rtl/dm_sba_arbiter_pkg.sv
// Shared types and constants for the debug-module system-bus arbiter.
//   SbaMaxOutstanding : default number of granted-but-unanswered transactions
//   SbaBusWidth       : default bus width used by sba_req_t
//   sba_req_t         : one requester's address phase (we, addr, be, wdata)
//   ptr_width()       : FIFO pointer width, never less than one bit
package dm_sba_arbiter_pkg;

  localparam int unsigned SbaMaxOutstanding = 2;
  localparam int unsigned SbaBusWidth       = 32;

  typedef struct packed {
    logic                     we;
    logic [SbaBusWidth-1:0]   addr;
    logic [SbaBusWidth/8-1:0] be;
    logic [SbaBusWidth-1:0]   wdata;
  } sba_req_t;

  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_sba_id_fifo.sv
// In-order FIFO of requester indices for granted bus transactions.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears contents)
//   push_i/data_i : enqueue an index
//   pop_i/data_o  : dequeue; data_o shows the oldest entry
//   full_o/empty_o: occupancy flags
module dm_sba_id_fifo
  import dm_sba_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rptr_q, wptr_q;
  logic [CntW-1:0]  cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_i) rptr_q <= ptr_inc(rptr_q);
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push_i && !pop_i) cnt_q <= cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing the debug module's system-bus master port.
//   req_i/we_i/addr_i/be_i/wdata_i : per-requester address phase (flattened)
//   gnt_o                          : one-hot grant, combinational from master_gnt_i
//   r_valid_o/r_rdata_o            : response routed to the issuing requester
//   master_*                       : the shared bus master port
//   resp_err_o                     : pulse on a response with nothing outstanding
module dm_sba_arbiter
  import dm_sba_arbiter_pkg::*;
#(
  parameter int unsigned NrMasters      = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = SbaMaxOutstanding
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrMasters-1:0]            req_i,
  input  logic [NrMasters-1:0]            we_i,
  input  logic [NrMasters*BusWidth-1:0]   addr_i,
  input  logic [NrMasters*BusWidth/8-1:0] be_i,
  input  logic [NrMasters*BusWidth-1:0]   wdata_i,
  output logic [NrMasters-1:0]            gnt_o,
  output logic [NrMasters-1:0]            r_valid_o,
  output logic [BusWidth-1:0]             r_rdata_o,
  output logic                            master_req_o,
  output logic [BusWidth-1:0]             master_add_o,
  output logic                            master_we_o,
  output logic [BusWidth-1:0]             master_wdata_o,
  output logic [BusWidth/8-1:0]           master_be_o,
  input  logic                            master_gnt_i,
  input  logic                            master_r_valid_i,
  input  logic [BusWidth-1:0]             master_r_rdata_i,
  output logic                            resp_err_o
);

  localparam int unsigned IdxW = $clog2(NrMasters);
  localparam int unsigned BeW  = BusWidth / 8;

  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;

  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic            fifo_full, fifo_empty;
  logic [IdxW-1:0] head_idx;
  logic            grant, pop;

  // Winner: the locked index, otherwise the first requester at or after rr_q.
  always_comb begin
    int unsigned cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (lock_q) begin
      win_valid = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NrMasters; i++) begin
        cand = (int'(rr_q) + i) % NrMasters;
        if (!win_valid && req_i[cand]) begin
          win_valid = 1'b1;
          win_idx   = IdxW'(cand);
        end
      end
    end
  end

  // Outputs are forced low while reset is held so nothing leaks onto the bus.
  always_comb begin
    master_req_o   = rst_ni & win_valid & ~fifo_full;
    grant          = master_req_o & master_gnt_i;
    pop            = rst_ni & master_r_valid_i & ~fifo_empty;
    resp_err_o     = rst_ni & master_r_valid_i & fifo_empty;
    gnt_o          = grant ? (NrMasters'(1) << win_idx) : '0;
    r_valid_o      = pop ? (NrMasters'(1) << head_idx) : '0;
    r_rdata_o      = pop ? master_r_rdata_i : '0;
    master_add_o   = '0;
    master_we_o    = 1'b0;
    master_wdata_o = '0;
    master_be_o    = '0;
    if (rst_ni && win_valid) begin
      master_add_o   = addr_i[int'(win_idx)*BusWidth +: BusWidth];
      master_we_o    = we_i[win_idx];
      master_wdata_o = wdata_i[int'(win_idx)*BusWidth +: BusWidth];
      master_be_o    = be_i[int'(win_idx)*BeW +: BeW];
    end
  end

  // A request left ungranted is locked so its address phase stays stable.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (grant) begin
      rr_d   = (win_idx == IdxW'(NrMasters - 1)) ? '0 : win_idx + 1'b1;
      lock_d = 1'b0;
    end else if (master_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  dm_sba_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .pop_i   (pop),
    .data_i  (win_idx),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_dm_sba_arbiter.sv
module tb_dm_sba_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we;
  logic [N*W-1:0]  addr, wdata;
  logic [N*W/8-1:0] be;
  logic [N-1:0]    gnt, rvalid;
  logic [W-1:0]    rdata;
  logic            mreq, mwe, mgnt, mrv, err;
  logic [W-1:0]    madd, mwdata, mrd;
  logic [W/8-1:0]  mbe;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_sba_arbiter #(
    .NrMasters      (N),
    .BusWidth       (W),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_i            (req),
    .we_i             (we),
    .addr_i           (addr),
    .be_i             (be),
    .wdata_i          (wdata),
    .gnt_o            (gnt),
    .r_valid_o        (rvalid),
    .r_rdata_o        (rdata),
    .master_req_o     (mreq),
    .master_add_o     (madd),
    .master_we_o      (mwe),
    .master_wdata_o   (mwdata),
    .master_be_o      (mbe),
    .master_gnt_i     (mgnt),
    .master_r_valid_i (mrv),
    .master_r_rdata_i (mrd),
    .resp_err_o       (err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of outstanding requester ids, round-robin start, locked id.
  int m_q[$];
  int m_rr = 0;
  int m_lock = -1;
  int s_push = -1;
  bit s_pop = 0;
  int s_rr = 0;
  int s_lock = -1;

  always @(negedge clk) begin
    int win, c;
    bit full, e_mreq, e_grant, e_pop;
    logic [N-1:0] e_gnt, e_rv;
    logic [W-1:0] e_add, e_wd, e_rd;
    logic [W/8-1:0] e_be;
    logic e_we, e_err;
    win = -1; e_mreq = 0; e_grant = 0; e_pop = 0; e_gnt = '0; e_rv = '0;
    e_add = '0; e_wd = '0; e_rd = '0; e_be = '0; e_we = 0; e_err = 0;
    if (rst_n) begin
      if (m_lock >= 0) win = m_lock;
      else for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (win < 0 && req[c]) win = c;
      end
      full = (m_q.size() == MO);
      e_mreq = (win >= 0) && !full;
      if (win >= 0) begin
        e_add = addr[win*W +: W];
        e_wd  = wdata[win*W +: W];
        e_be  = be[win*(W/8) +: W/8];
        e_we  = we[win];
      end
      e_grant = e_mreq && mgnt;
      if (e_grant) e_gnt[win] = 1'b1;
      if (mrv) begin
        if (m_q.size() > 0) begin
          e_pop = 1;
          e_rv[m_q[0]] = 1'b1;
          e_rd = mrd;
        end else e_err = 1;
      end
    end
    chk("gnt_o", gnt, e_gnt);
    chk("r_valid_o", rvalid, e_rv);
    chk("r_rdata_o", rdata, e_rd);
    chk("master_req_o", mreq, e_mreq);
    chk("master_add_o", madd, e_add);
    chk("master_we_o", mwe, e_we);
    chk("master_wdata_o", mwdata, e_wd);
    chk("master_be_o", mbe, e_be);
    chk("resp_err_o", err, e_err);
    s_pop  = e_pop;
    s_push = e_grant ? win : -1;
    s_rr   = e_grant ? (win + 1) % N : m_rr;
    s_lock = e_grant ? -1 : (e_mreq ? win : m_lock);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rr = 0;
      m_lock = -1;
    end else begin
      if (s_pop) void'(m_q.pop_front());
      if (s_push >= 0) m_q.push_back(s_push);
      m_rr = s_rr;
      m_lock = s_lock;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [N-1:0] g;

  initial begin
    rst_n = 1'b0; req = 2'b11; we = 2'b10; mgnt = 1'b0; mrv = 1'b0; mrd = '0;
    addr = {32'h0000_0200, 32'h0000_0100};
    wdata = {32'hBBBB_0002, 32'hAAAA_0001};
    be = {4'hC, 4'h3};
    repeat (3) @(posedge clk);
    at_neg(); chk("rst_mreq", mreq, 0); chk("rst_gnt", gnt, 0); chk("rst_add", madd, 0);

    // Release with grant high: requester 0 wins first.
    step(); rst_n = 1'b1; mgnt = 1'b1;
    at_neg(); chk("rel_gnt", gnt, 2'b01);
    // Round-robin with responses one cycle behind.
    step(); mrv = 1'b1; mrd = 32'h11;
    at_neg(); chk("rr_gnt1", gnt, 2'b10); chk("rr_rv1", rvalid, 2'b01);
    step(); mrd = 32'h22;
    at_neg(); chk("rr_gnt2", gnt, 2'b01); chk("rr_rv2", rvalid, 2'b10);
    step(); mrd = 32'h33;
    at_neg(); chk("rr_gnt3", gnt, 2'b10); chk("rr_rv3", rvalid, 2'b01);
    step(); req = 2'b00; mgnt = 1'b0;
    at_neg(); chk("rr_rv4", rvalid, 2'b10);

    // Lock: requester 1 held off, requester 0 arrives but must not steal the bus.
    step(); req = 2'b10; mrv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg(); chk("lock_add", madd, 32'h200);
      step();
    end
    req = 2'b11;
    at_neg(); chk("lock_add_hi", madd, 32'h200);
    step(); mgnt = 1'b1;
    at_neg(); chk("lock_gnt", gnt, 2'b10);
    step(); req = 2'b00; mgnt = 1'b0; mrv = 1'b1; mrd = 32'h44;
    at_neg(); chk("lock_rv", rvalid, 2'b10);

    // Full: two grants then a blocked third request.
    step(); req = 2'b01; mgnt = 1'b1; mrv = 1'b0;
    at_neg(); chk("full_g0", gnt, 2'b01);
    step(); req = 2'b10;
    at_neg(); chk("full_g1", gnt, 2'b10);
    step(); req = 2'b01;
    at_neg(); chk("full_blk", mreq, 0); chk("full_gnt", gnt, 0);
    step(); mrv = 1'b1; mrd = 32'hDEADBEEF;
    at_neg(); chk("full_rv", rvalid, 2'b01); chk("full_rd", rdata, 32'hDEADBEEF);
    chk("full_blk2", mreq, 0);
    step(); mrv = 1'b0;
    at_neg(); chk("full_req", mreq, 1); chk("full_g2", gnt, 2'b01);

    // Simultaneous push and pop with one entry outstanding.
    step(); req = 2'b00; mrv = 1'b1; mrd = 32'h55;
    at_neg(); chk("sim_drain", rvalid, 2'b10);
    step(); req = 2'b10; mrd = 32'h66;
    at_neg(); chk("sim_gnt", gnt, 2'b10); chk("sim_rv", rvalid, 2'b01);
    step(); req = 2'b01; mrv = 1'b0;
    at_neg(); chk("sim_occ1", mreq, 1); chk("sim_g", gnt, 2'b01);
    step();
    at_neg(); chk("sim_full", mreq, 0);
    step(); req = 2'b00; mrv = 1'b1;
    at_neg(); chk("sim_rvA", rvalid, 2'b10);
    step();
    at_neg(); chk("sim_rvB", rvalid, 2'b01);

    // Unexpected response with nothing outstanding.
    step();
    at_neg(); chk("unexp_err", err, 1); chk("unexp_rv", rvalid, 0);
    step(); mrv = 1'b0;
    at_neg(); chk("unexp_clr", err, 0);

    // Reset mid-flight, then a late response.
    step(); req = 2'b01; mgnt = 1'b1;
    at_neg(); chk("mid_gnt", gnt, 2'b01);
    step(); req = 2'b00; mgnt = 1'b0; rst_n = 1'b0;
    at_neg(); chk("mid_rst", mreq, 0);
    step(); rst_n = 1'b1;
    step(); mrv = 1'b1;
    at_neg(); chk("late_err", err, 1); chk("late_rv", rvalid, 0);
    step(); mrv = 1'b0;

    // Randomized traffic; a requester holds its phase until granted.
    g = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req[i] || g[i]) begin
          if ($urandom % 2 == 1) begin
            req[i] = 1'b1;
            we[i] = 1'($urandom);
            addr[i*W +: W] = $urandom;
            wdata[i*W +: W] = $urandom;
            be[i*(W/8) +: W/8] = 4'($urandom);
          end else req[i] = 1'b0;
        end
      end
      mgnt = ($urandom % 4) != 0;
      mrv  = ($urandom % 3) == 0;
      mrd  = $urandom;
      at_neg();
      g = gnt;
    end
    step(); req = '0; mgnt = 1'b0; mrv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
